// File: rtl/lsu_ctrl_pkg.sv
// Shared definitions for the load/store unit: bus widths, access-size codes,
// FSM state encoding and a misalignment helper.
// Optional feature macro: LSU_MISALGN_CHK_EN (misaligned-access error path).
`ifndef LSU_CTRL_DEFINES
`define LSU_CTRL_DEFINES
`define XLEN            32
`define ITAG_WIDTH      4
`define DTCM_ADDR_WIDTH 16
`endif

package lsu_ctrl_pkg;

    localparam int XLEN   = `XLEN;
    localparam int ITAG_W = `ITAG_WIDTH;
    localparam int AW     = `DTCM_ADDR_WIDTH;
    localparam int MASK_W = XLEN / 8;

    // Access size encoding on agu_cmd_size (3 is treated as word)
    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RSP    = 2'd2,
        ST_WBCK   = 2'd3
    } lsu_state_e;

    // Half on an odd byte, or word not on a word boundary
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] ofs);
        return ((size == SIZE_H) && ofs[0]) || (size[1] && (ofs != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_ld_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and applies
// zero/sign extension for byte and half loads.
module lsu_ld_align
    import lsu_ctrl_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      ofs,
    input  logic [1:0]      size,
    input  logic            usign,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] shifted;
    logic            ext_bit;

    assign shifted = rdata >> {ofs, 3'b000};

    // Select width and extension; word loads pass the shifted word through
    always_comb begin
        data    = shifted;
        ext_bit = 1'b0;
        case (size)
            SIZE_B: begin
                ext_bit = ~usign & shifted[7];
                data    = {{(XLEN-8){ext_bit}}, shifted[7:0]};
            end
            SIZE_H: begin
                ext_bit = ~usign & shifted[15];
                data    = {{(XLEN-16){ext_bit}}, shifted[15:0]};
            end
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit controller: accepts one AGU command at a time, performs a
// single DTCM access, returns an AGU response and, for loads, a write-back.
// Optional feature macro: LSU_MISALGN_CHK_EN adds agu_rsp_err and skips the
// SRAM access for misaligned half/word accesses.
module lsu_ctrl
    import lsu_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    // AGU command
    input  logic              agu_cmd_valid,
    output logic              agu_cmd_ready,
    input  logic [AW-1:0]     agu_cmd_addr,
    input  logic              agu_cmd_read,
    input  logic [ITAG_W-1:0] agu_cmd_itag,
    input  logic [1:0]        agu_cmd_size,
    input  logic              agu_cmd_usign,
    input  logic [XLEN-1:0]   agu_cmd_wdata,
    input  logic [MASK_W-1:0] agu_cmd_wmask,
    // AGU response
    output logic              agu_rsp_valid,
    input  logic              agu_rsp_ready,
`ifdef LSU_MISALGN_CHK_EN
    output logic              agu_rsp_err,
`endif
    // Long-pipe write-back
    output logic              lsu_wbck_o_valid,
    input  logic              lsu_wbck_o_ready,
    output logic [XLEN-1:0]   lsu_wbck_o_data,
    output logic [ITAG_W-1:0] lsu_wbck_o_itag,
    // DTCM SRAM
    output logic              dtcm_cs,
    output logic              dtcm_we,
    output logic [AW-3:0]     dtcm_addr,
    output logic [XLEN-1:0]   dtcm_wdata,
    output logic [MASK_W-1:0] dtcm_wem,
    input  logic [XLEN-1:0]   dtcm_rdata
);

    lsu_state_e        state_reg;
    logic              cmd_ready_reg;
    logic              rsp_valid_reg;
    logic              wbck_valid_reg;
    logic              cs_reg;
    logic              we_reg;
    logic              rsp_first_reg;
    logic [AW-1:0]     addr_reg;
    logic              read_reg;
    logic [ITAG_W-1:0] itag_reg;
    logic [1:0]        size_reg;
    logic              usign_reg;
    logic [XLEN-1:0]   wdata_reg;
    logic [MASK_W-1:0] wmask_reg;
    logic [XLEN-1:0]   ld_data_reg;
    logic [XLEN-1:0]   aligned_data;
    logic              cmd_fire;
    logic              cmd_mis;

`ifdef LSU_MISALGN_CHK_EN
    logic              err_reg;
    assign cmd_mis     = is_misaligned(agu_cmd_size, agu_cmd_addr[1:0]);
    assign agu_rsp_err = rsp_valid_reg & err_reg;
`else
    assign cmd_mis     = 1'b0;
`endif

    assign cmd_fire = agu_cmd_valid & cmd_ready_reg;

    lsu_ld_align u_ld_align (
        .rdata (dtcm_rdata),
        .ofs   (addr_reg[1:0]),
        .size  (size_reg),
        .usign (usign_reg),
        .data  (aligned_data)
    );

    assign agu_cmd_ready    = cmd_ready_reg;
    assign agu_rsp_valid    = rsp_valid_reg;
    assign lsu_wbck_o_valid = wbck_valid_reg;
    assign lsu_wbck_o_data  = ld_data_reg;
    assign lsu_wbck_o_itag  = itag_reg;
    assign dtcm_cs          = cs_reg;
    assign dtcm_we          = we_reg;
    assign dtcm_addr        = addr_reg[AW-1:2];
    assign dtcm_wdata       = wdata_reg;
    assign dtcm_wem         = wmask_reg;

    // Transaction FSM with registered handshake and SRAM control outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            cmd_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            wbck_valid_reg <= 1'b0;
            cs_reg         <= 1'b0;
            we_reg         <= 1'b0;
            rsp_first_reg  <= 1'b0;
            addr_reg       <= '0;
            read_reg       <= 1'b0;
            itag_reg       <= '0;
            size_reg       <= '0;
            usign_reg      <= 1'b0;
            wdata_reg      <= '0;
            wmask_reg      <= '0;
            ld_data_reg    <= '0;
`ifdef LSU_MISALGN_CHK_EN
            err_reg        <= 1'b0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (cmd_fire) begin
                        addr_reg      <= agu_cmd_addr;
                        read_reg      <= agu_cmd_read;
                        itag_reg      <= agu_cmd_itag;
                        size_reg      <= agu_cmd_size;
                        usign_reg     <= agu_cmd_usign;
                        wdata_reg     <= agu_cmd_wdata;
                        wmask_reg     <= agu_cmd_wmask;
                        // A misaligned access never reaches the SRAM
                        cs_reg        <= ~cmd_mis;
                        we_reg        <= ~cmd_mis & ~agu_cmd_read;
                        cmd_ready_reg <= 1'b0;
`ifdef LSU_MISALGN_CHK_EN
                        err_reg       <= cmd_mis;
`endif
                        state_reg     <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    cs_reg        <= 1'b0;
                    we_reg        <= 1'b0;
                    rsp_valid_reg <= 1'b1;
                    rsp_first_reg <= 1'b1;
                    state_reg     <= ST_RSP;
                end
                ST_RSP: begin
                    rsp_first_reg <= 1'b0;
                    // SRAM read data is only valid in the first RSP cycle
                    if (rsp_first_reg && read_reg) begin
`ifdef LSU_MISALGN_CHK_EN
                        ld_data_reg <= err_reg ? '0 : aligned_data;
`else
                        ld_data_reg <= aligned_data;
`endif
                    end
                    if (agu_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        if (read_reg) begin
                            wbck_valid_reg <= 1'b1;
                            state_reg      <= ST_WBCK;
                        end else begin
                            cmd_ready_reg  <= 1'b1;
                            state_reg      <= ST_IDLE;
                        end
                    end
                end
                ST_WBCK: begin
                    if (lsu_wbck_o_ready) begin
                        wbck_valid_reg <= 1'b0;
                        cmd_ready_reg  <= 1'b1;
                        state_reg      <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed self-checking bench for lsu_ctrl with a behavioural DTCM model and
// a write-back scoreboard. Honours LSU_MISALGN_CHK_EN when defined.
module tb_lsu_ctrl;
    import lsu_ctrl_pkg::*;

    logic              clk;
    logic              rst;
    logic              agu_cmd_valid;
    logic              agu_cmd_ready;
    logic [AW-1:0]     agu_cmd_addr;
    logic              agu_cmd_read;
    logic [ITAG_W-1:0] agu_cmd_itag;
    logic [1:0]        agu_cmd_size;
    logic              agu_cmd_usign;
    logic [XLEN-1:0]   agu_cmd_wdata;
    logic [MASK_W-1:0] agu_cmd_wmask;
    logic              agu_rsp_valid;
    logic              agu_rsp_ready;
`ifdef LSU_MISALGN_CHK_EN
    logic              agu_rsp_err;
`endif
    logic              lsu_wbck_o_valid;
    logic              lsu_wbck_o_ready;
    logic [XLEN-1:0]   lsu_wbck_o_data;
    logic [ITAG_W-1:0] lsu_wbck_o_itag;
    logic              dtcm_cs;
    logic              dtcm_we;
    logic [AW-3:0]     dtcm_addr;
    logic [XLEN-1:0]   dtcm_wdata;
    logic [MASK_W-1:0] dtcm_wem;
    logic [XLEN-1:0]   dtcm_rdata;

    // Backdoor preload port into the SRAM model
    logic              bd_we;
    logic [AW-3:0]     bd_addr;
    logic [XLEN-1:0]   bd_data;
    logic [XLEN-1:0]   mem [0:(1<<(AW-2))-1];

    typedef struct packed {
        logic [XLEN-1:0]   data;
        logic [ITAG_W-1:0] itag;
    } wbck_t;
    wbck_t sb_q[$];

    int checks = 0;
    int errors = 0;

    lsu_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .agu_cmd_valid    (agu_cmd_valid),
        .agu_cmd_ready    (agu_cmd_ready),
        .agu_cmd_addr     (agu_cmd_addr),
        .agu_cmd_read     (agu_cmd_read),
        .agu_cmd_itag     (agu_cmd_itag),
        .agu_cmd_size     (agu_cmd_size),
        .agu_cmd_usign    (agu_cmd_usign),
        .agu_cmd_wdata    (agu_cmd_wdata),
        .agu_cmd_wmask    (agu_cmd_wmask),
        .agu_rsp_valid    (agu_rsp_valid),
        .agu_rsp_ready    (agu_rsp_ready),
`ifdef LSU_MISALGN_CHK_EN
        .agu_rsp_err      (agu_rsp_err),
`endif
        .lsu_wbck_o_valid (lsu_wbck_o_valid),
        .lsu_wbck_o_ready (lsu_wbck_o_ready),
        .lsu_wbck_o_data  (lsu_wbck_o_data),
        .lsu_wbck_o_itag  (lsu_wbck_o_itag),
        .dtcm_cs          (dtcm_cs),
        .dtcm_we          (dtcm_we),
        .dtcm_addr        (dtcm_addr),
        .dtcm_wdata       (dtcm_wdata),
        .dtcm_wem         (dtcm_wem),
        .dtcm_rdata       (dtcm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM model: byte-masked write, read data valid one cycle after cs
    always @(posedge clk) begin
        if (bd_we) begin
            mem[bd_addr] <= bd_data;
        end else if (dtcm_cs) begin
            if (dtcm_we) begin
                for (int b = 0; b < MASK_W; b++)
                    if (dtcm_wem[b]) mem[dtcm_addr][8*b +: 8] <= dtcm_wdata[8*b +: 8];
            end else begin
                dtcm_rdata <= mem[dtcm_addr];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [AW-3:0] a, input logic [XLEN-1:0] d);
        bd_we   = 1'b1;
        bd_addr = a;
        bd_data = d;
        tick();
        bd_we   = 1'b0;
    endtask

    // One complete command with both ready inputs held high
    task automatic do_cmd(input string name, input logic rd, input logic [AW-1:0] addr,
                          input logic [ITAG_W-1:0] itag, input logic [1:0] size,
                          input logic usign, input logic [XLEN-1:0] wdata,
                          input logic [MASK_W-1:0] wmask, input logic exp_cs,
                          input logic exp_err, input logic [XLEN-1:0] exp_data);
        wbck_t e;
        check({name, ".cmd_ready_T"}, {31'b0, agu_cmd_ready}, 32'd1);
        agu_cmd_valid = 1'b1;
        agu_cmd_read  = rd;
        agu_cmd_addr  = addr;
        agu_cmd_itag  = itag;
        agu_cmd_size  = size;
        agu_cmd_usign = usign;
        agu_cmd_wdata = wdata;
        agu_cmd_wmask = wmask;
        if (rd) sb_q.push_back('{data: exp_data, itag: itag});
        tick();
        agu_cmd_valid = 1'b0;
        check({name, ".cs_T1"}, {31'b0, dtcm_cs}, {31'b0, exp_cs});
        if (exp_cs) begin
            check({name, ".addr_T1"}, {{(34-AW){1'b0}}, dtcm_addr}, {{(34-AW){1'b0}}, addr[AW-1:2]});
            check({name, ".we_T1"}, {31'b0, dtcm_we}, {31'b0, ~rd});
            if (!rd) begin
                check({name, ".wem_T1"}, {28'b0, dtcm_wem}, {28'b0, wmask});
                check({name, ".wdata_T1"}, dtcm_wdata, wdata);
            end
        end
        check({name, ".rsp_early_T1"}, {31'b0, agu_rsp_valid}, 32'd0);
        tick();
        check({name, ".rsp_T2"}, {31'b0, agu_rsp_valid}, 32'd1);
        check({name, ".cs_T2"}, {31'b0, dtcm_cs}, 32'd0);
`ifdef LSU_MISALGN_CHK_EN
        check({name, ".err_T2"}, {31'b0, agu_rsp_err}, {31'b0, exp_err});
`else
        check({name, ".exp_err_unused"}, {31'b0, exp_err}, {31'b0, exp_err & agu_rsp_valid});
`endif
        tick();
        if (rd) begin
            check({name, ".wbck_T3"}, {31'b0, lsu_wbck_o_valid}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check({name, ".wbck_data"}, lsu_wbck_o_data, e.data);
                check({name, ".wbck_itag"}, {28'b0, lsu_wbck_o_itag}, {28'b0, e.itag});
            end else begin
                check({name, ".sb_empty"}, 32'd0, 32'd1);
            end
            check({name, ".cmd_ready_T3"}, {31'b0, agu_cmd_ready}, 32'd0);
            tick();
        end
        check({name, ".wbck_idle"}, {31'b0, lsu_wbck_o_valid}, 32'd0);
        check({name, ".cmd_ready_end"}, {31'b0, agu_cmd_ready}, 32'd1);
        $display("txn %s rd=%0d addr=%h itag=%0d wbck=%h", name, rd, addr, itag, lsu_wbck_o_data);
    endtask

    initial begin
        wbck_t e;
        rst = 1'b1;
        agu_cmd_valid = 1'b0; agu_cmd_addr = '0; agu_cmd_read = 1'b0; agu_cmd_itag = '0;
        agu_cmd_size = 2'd0; agu_cmd_usign = 1'b0; agu_cmd_wdata = '0; agu_cmd_wmask = '0;
        agu_rsp_ready = 1'b1; lsu_wbck_o_ready = 1'b1;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        tick();
        check("rst.rsp_valid", {31'b0, agu_rsp_valid}, 32'd0);
        check("rst.wbck_valid", {31'b0, lsu_wbck_o_valid}, 32'd0);
        check("rst.cs", {31'b0, dtcm_cs}, 32'd0);
        check("rst.we", {31'b0, dtcm_we}, 32'd0);
        check("rst.wbck_data", lsu_wbck_o_data, 32'd0);
        check("rst.wbck_itag", {28'b0, lsu_wbck_o_itag}, 32'd0);
        preload(14'd4, 32'hDEADBEEF);
        preload(14'd2, 32'h11223344);
        preload(14'd8, 32'hCAFE8001);
        rst = 1'b0;
        tick();
        check("rst.cmd_ready", {31'b0, agu_cmd_ready}, 32'd1);

        // Word, byte and half loads
        do_cmd("ld_word", 1'b1, 16'h0010, 4'd2, SIZE_W, 1'b0, '0, '0, 1'b1, 1'b0, 32'hDEADBEEF);
        preload(14'd4, 32'h80FF1234);
        do_cmd("ld_byte_s", 1'b1, 16'h0013, 4'd1, SIZE_B, 1'b0, '0, '0, 1'b1, 1'b0, 32'hFFFFFF80);
        do_cmd("ld_byte_u", 1'b1, 16'h0013, 4'd6, SIZE_B, 1'b1, '0, '0, 1'b1, 1'b0, 32'h00000080);
        do_cmd("ld_byte_pos", 1'b1, 16'h0011, 4'd7, SIZE_B, 1'b0, '0, '0, 1'b1, 1'b0, 32'h00000012);
        do_cmd("ld_half_s", 1'b1, 16'h0012, 4'd3, SIZE_H, 1'b0, '0, '0, 1'b1, 1'b0, 32'hFFFF80FF);
        do_cmd("ld_half_u", 1'b1, 16'h0012, 4'd4, SIZE_H, 1'b1, '0, '0, 1'b1, 1'b0, 32'h000080FF);

        // Store then read back the merged word
        do_cmd("st_byte1", 1'b0, 16'h0008, 4'd9, SIZE_B, 1'b0, 32'h0000AB00, 4'b0010, 1'b1, 1'b0, '0);
        check("st.sb_no_entry", sb_q.size(), 32'd0);
        do_cmd("ld_after_st", 1'b1, 16'h0008, 4'd10, SIZE_W, 1'b0, '0, '0, 1'b1, 1'b0, 32'h1122AB44);

        // Misaligned half load
`ifdef LSU_MISALGN_CHK_EN
        do_cmd("ld_mis_half", 1'b1, 16'h0021, 4'd5, SIZE_H, 1'b0, '0, '0, 1'b0, 1'b1, 32'h00000000);
`else
        do_cmd("ld_mis_half", 1'b1, 16'h0021, 4'd5, SIZE_H, 1'b0, '0, '0, 1'b1, 1'b0, 32'hFFFFFE80);
`endif

        // Back-pressure: rsp_ready low 5 cycles, then wbck_ready low 3 cycles
        agu_rsp_ready = 1'b0;
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b1; agu_cmd_addr = 16'h0010;
        agu_cmd_itag = 4'd11; agu_cmd_size = SIZE_W; agu_cmd_usign = 1'b0;
        sb_q.push_back('{data: 32'h80FF1234, itag: 4'd11});
        tick();
        agu_cmd_valid = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("bp.rsp_hold", {31'b0, agu_rsp_valid}, 32'd1);
            check("bp.rsp_cmd_ready", {31'b0, agu_cmd_ready}, 32'd0);
            check("bp.rsp_no_wbck", {31'b0, lsu_wbck_o_valid}, 32'd0);
            tick();
        end
        agu_rsp_ready = 1'b1;
        lsu_wbck_o_ready = 1'b0;
        tick();
        e = '{data: 32'hFFFFFFFF, itag: 4'hF};
        if (sb_q.size() != 0) e = sb_q.pop_front();
        for (int i = 0; i < 3; i++) begin
            check("bp.wbck_hold", {31'b0, lsu_wbck_o_valid}, 32'd1);
            check("bp.wbck_data", lsu_wbck_o_data, e.data);
            check("bp.wbck_itag", {28'b0, lsu_wbck_o_itag}, {28'b0, e.itag});
            check("bp.wbck_cmd_ready", {31'b0, agu_cmd_ready}, 32'd0);
            check("bp.wbck_rsp_low", {31'b0, agu_rsp_valid}, 32'd0);
            tick();
        end
        lsu_wbck_o_ready = 1'b1;
        check("bp.wbck_release", {31'b0, lsu_wbck_o_valid}, 32'd1);
        tick();
        check("bp.single_wbck", {31'b0, lsu_wbck_o_valid}, 32'd0);
        check("bp.cmd_ready_end", {31'b0, agu_cmd_ready}, 32'd1);
        $display("txn bp_load itag=%0d wbck=%h", e.itag, e.data);

        // Reset during RSP of a load abandons it
        agu_rsp_ready = 1'b0;
        agu_cmd_valid = 1'b1; agu_cmd_read = 1'b1; agu_cmd_addr = 16'h0010;
        agu_cmd_itag = 4'd12; agu_cmd_size = SIZE_W;
        tick();
        agu_cmd_valid = 1'b0;
        tick();
        check("rstmid.in_rsp", {31'b0, agu_rsp_valid}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid.async_rsp", {31'b0, agu_rsp_valid}, 32'd0);
        tick();
        rst = 1'b0;
        agu_rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("rstmid.no_rsp", {31'b0, agu_rsp_valid}, 32'd0);
            check("rstmid.no_wbck", {31'b0, lsu_wbck_o_valid}, 32'd0);
            check("rstmid.cmd_ready", {31'b0, agu_cmd_ready}, 32'd1);
            tick();
        end
        $display("txn rst_abandon itag=12");
        do_cmd("ld_after_rst", 1'b1, 16'h0010, 4'd13, SIZE_W, 1'b0, '0, '0, 1'b1, 1'b0, 32'h80FF1234);

        check("sb.drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
